// File: rtl/key_pulse_gen.sv
// Debounced pushbutton to single-cycle count-enable strobe, with optional
// hold-to-repeat after an initial delay.
module key_pulse_gen #(
    parameter int unsigned DB_CYCLES  = 50000,
    parameter int unsigned RPT_DELAY  = 25000000,
    parameter int unsigned RPT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n,
    input  logic rpt_en,
    output logic pulse,
    output logic pressed
);

    localparam int unsigned DBW     = $clog2(DB_CYCLES) + 1;
    localparam int unsigned IVL_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned IVW     = $clog2(IVL_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        HOLD
    } state_t;

    logic           sync1;
    logic           sync2;
    logic [DBW-1:0] db_cnt;
    logic           db_diff;
    logic           db_hit;
    logic           press_ev;
    logic           rel_ev;

    state_t         state;
    state_t         state_n;
    logic [IVW-1:0] ivl;
    logic [IVW-1:0] ivl_n;
    logic           pulse_n;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // The level flips on the edge where the count would reach DB_CYCLES,
    // so the count register itself never needs to hold DB_CYCLES.
    assign db_diff  = (~sync2) != pressed;
    assign db_hit   = db_diff && (db_cnt == DBW'(DB_CYCLES - 1));
    assign press_ev = db_hit && !pressed;
    assign rel_ev   = db_hit && pressed;

    always_ff @(posedge clk) begin
        if (clr) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else if (!db_diff) begin
            db_cnt  <= '0;
        end else if (db_hit) begin
            db_cnt  <= '0;
            pressed <= ~pressed;
        end else begin
            db_cnt  <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            ivl   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            ivl   <= ivl_n;
            pulse <= pulse_n;
        end
    end

    // Release outranks everything, then rpt_en=0, then a due repeat pulse.
    always_comb begin
        state_n = state;
        ivl_n   = ivl;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (press_ev) begin
                    state_n = DELAY;
                    ivl_n   = '0;
                    pulse_n = 1'b1;
                end
            end
            DELAY: begin
                if (rel_ev) begin
                    state_n = IDLE;
                    ivl_n   = '0;
                end else if (!rpt_en) begin
                    state_n = HOLD;
                    ivl_n   = '0;
                end else if (ivl == IVW'(RPT_DELAY - 1)) begin
                    state_n = REPEAT;
                    ivl_n   = '0;
                    pulse_n = 1'b1;
                end else begin
                    ivl_n   = ivl + 1'b1;
                end
            end
            REPEAT: begin
                if (rel_ev) begin
                    state_n = IDLE;
                    ivl_n   = '0;
                end else if (!rpt_en) begin
                    state_n = HOLD;
                    ivl_n   = '0;
                end else if (ivl == IVW'(RPT_PERIOD - 1)) begin
                    ivl_n   = '0;
                    pulse_n = 1'b1;
                end else begin
                    ivl_n   = ivl + 1'b1;
                end
            end
            HOLD: begin
                if (rel_ev) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                ivl_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3,
// plus an 8-bit enable counter fed by pulse.
module tb_key_pulse_gen;

    logic clk = 1'b0;
    logic clr;
    logic key_n;
    logic rpt_en;
    logic pulse;
    logic pressed;

    logic [7:0] cnt;
    logic [7:0] cnt_init;
    logic       cnt_ld;

    int total = 0;
    int bad   = 0;

    key_pulse_gen #(
        .DB_CYCLES (4),
        .RPT_DELAY (10),
        .RPT_PERIOD(3)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .key_n  (key_n),
        .rpt_en (rpt_en),
        .pulse  (pulse),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (cnt_ld)
            cnt <= cnt_init;
        else if (pulse)
            cnt <= cnt + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks n cycles, returning the pulse count and adjacent-high pairs seen.
    task automatic run(input int n, output int np, output int pairs);
        logic prev;
        np    = 0;
        pairs = 0;
        prev  = pulse;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pulse === 1'b1) np++;
            if (pulse === 1'b1 && prev === 1'b1) pairs++;
            prev = pulse;
        end
    endtask

    task automatic press_release();
        key_n = 1'b0;
        repeat (8) tick();
        key_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        int np;
        int pairs;
        int early;
        logic [1:0] e;

        clr      = 1'b1;
        key_n    = 1'b1;
        rpt_en   = 1'b0;
        cnt_ld   = 1'b1;
        cnt_init = 8'd0;
        repeat (3) tick();
        chk("reset", 32'({pressed, pulse}), 0);
        clr    = 1'b0;
        cnt_ld = 1'b0;

        // single press, no repeat
        key_n = 1'b0;
        early = 0;
        repeat (5) begin
            tick();
            if (pulse !== 1'b0 || pressed !== 1'b0) early++;
        end
        chk("press_early", 32'(early), 0);
        tick();
        chk("press_edge", 32'({pressed, pulse}), 32'h3);
        run(100, np, pairs);
        chk("press_quiet", 32'(np), 0);
        key_n = 1'b1;
        repeat (5) tick();
        chk("release_before", 32'(pressed), 1);
        tick();
        chk("release_edge", 32'({pressed, pulse}), 0);

        // bounce: 3 low, 1 high, then held low
        key_n = 1'b0;
        early = 0;
        repeat (3) begin
            tick();
            if (pulse !== 1'b0) early++;
        end
        key_n = 1'b1;
        tick();
        if (pulse !== 1'b0) early++;
        key_n = 1'b0;
        repeat (5) begin
            tick();
            if (pulse !== 1'b0) early++;
        end
        chk("bounce_early", 32'(early), 0);
        tick();
        chk("bounce_pulse", 32'({pressed, pulse}), 32'h3);
        key_n = 1'b1;
        run(10, np, pairs);
        chk("bounce_rel_pulses", 32'(np), 0);
        chk("bounce_rel_level", 32'(pressed), 0);

        // auto-repeat; release timed so the release edge meets a due repeat
        rpt_en = 1'b1;
        key_n  = 1'b0;
        repeat (6) tick();
        chk("rpt_initial", 32'({pressed, pulse}), 32'h3);
        for (int t = 1; t <= 28; t++) begin
            if (t == 23) key_n = 1'b1;
            tick();
            e[0] = (t >= 10) && ((t - 10) % 3 == 0) && (t != 28);
            e[1] = (t < 28);
            chk($sformatf("rpt_t%0d", t), 32'({pressed, pulse}), 32'(e));
        end
        run(20, np, pairs);
        chk("rpt_after_release", 32'(np), 0);

        // repeat disable, re-enable while held, then re-press
        key_n = 1'b0;
        repeat (6) tick();
        chk("dis_initial", 32'(pulse), 1);
        for (int t = 1; t <= 15; t++) begin
            if (t == 15) rpt_en = 1'b0;
            tick();
            e[0] = (t == 10) || (t == 13);
            chk($sformatf("dis_t%0d", t), 32'(pulse), 32'(e[0]));
        end
        rpt_en = 1'b1;
        run(30, np, pairs);
        chk("dis_hold", 32'(np), 0);
        key_n = 1'b1;
        run(10, np, pairs);
        chk("dis_release", 32'({np[0], pressed}), 0);
        rpt_en = 1'b0;
        key_n  = 1'b0;
        repeat (6) tick();
        chk("dis_repress", 32'(pulse), 1);
        run(30, np, pairs);
        chk("dis_repress_quiet", 32'(np), 0);
        key_n = 1'b1;
        repeat (10) tick();

        // clear during REPEAT on the edge a repeat pulse is due
        rpt_en = 1'b1;
        key_n  = 1'b0;
        repeat (6) tick();
        chk("clr_initial", 32'(pulse), 1);
        run(12, np, pairs);
        chk("clr_first_rpt", 32'(np), 1);
        clr = 1'b1;
        tick();
        chk("clr_edge", 32'({pressed, pulse}), 0);
        clr   = 1'b0;
        early = 0;
        repeat (5) begin
            tick();
            if (pulse !== 1'b0 || pressed !== 1'b0) early++;
        end
        chk("clr_relatency", 32'(early), 0);
        tick();
        chk("clr_new_press", 32'({pressed, pulse}), 32'h3);
        rpt_en = 1'b0;
        key_n  = 1'b1;
        run(10, np, pairs);
        chk("clr_release", 32'(pressed), 0);

        // downstream enable counter
        cnt_init = 8'd255;
        cnt_ld   = 1'b1;
        tick();
        cnt_ld = 1'b0;
        chk("cnt_load", 32'(cnt), 32'hff);
        press_release();
        chk("cnt_wrap", 32'(cnt), 0);
        cnt_init = 8'd0;
        cnt_ld   = 1'b1;
        tick();
        cnt_ld = 1'b0;
        repeat (16) press_release();
        chk("cnt_16", 32'(cnt), 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
